// File: rtl/data_mmu.sv
// data_mmu: pipelined data-side address translator (direct mode, DMW windows,
// optional fully-associative 4 KiB TLB). Result is registered one cycle after
// acceptance. Optional feature macro: DMMU_TLB_EN (builds the TLB).
module data_mmu #(
    parameter int DMW_NUM     = 2,
    parameter int TLB_ENTRIES = 8,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    input  logic                   req_store,
    input  logic [1:0]             plv,
    input  logic [9:0]             asid,
    input  logic [1:0]             translate_mode,
    input  logic [1:0]             direct_d_mat,
    input  logic [DMW_NUM-1:0]     dmw_plv0,
    input  logic [DMW_NUM-1:0]     dmw_plv3,
    input  logic [2*DMW_NUM-1:0]   dmw_mat,
    input  logic [3*DMW_NUM-1:0]   dmw_vseg,
    input  logic [3*DMW_NUM-1:0]   dmw_pseg,
    input  logic                   tlb_we,
    input  logic [IDX_W-1:0]       tlb_idx,
    input  logic [19:0]            tlb_vppn,
    input  logic [19:0]            tlb_ppn,
    input  logic [9:0]             tlb_asid,
    input  logic                   tlb_g,
    input  logic                   tlb_v,
    input  logic                   tlb_d,
    input  logic [1:0]             tlb_plv,
    input  logic [1:0]             tlb_mat,
    input  logic                   tlb_inv_all,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            paddr,
    output logic                   uncache,
    output logic [2:0]             exc
);

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_TLBR = 3'd1;
    localparam logic [2:0] EXC_PIL  = 3'd2;
    localparam logic [2:0] EXC_PIS  = 3'd3;
    localparam logic [2:0] EXC_PPI  = 3'd4;
    localparam logic [2:0] EXC_PME  = 3'd5;

    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        paddr_q, paddr_d;
    logic               uncache_q, uncache_d;
    logic [2:0]         exc_q, exc_d;
    logic               accept_s;
    logic               paged_s;
    logic [DMW_NUM-1:0] win_en_s;
    logic               dmw_hit_s;
    logic [2:0]         dmw_pseg_s;
    logic               dmw_mat0_s;
    logic [31:0]        miss_paddr_s;
    logic               miss_unc_s;
    logic [2:0]         miss_exc_s;
    logic               unused_s;

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept_s  = req_valid && req_ready;
    assign paged_s   = (translate_mode == 2'b10);

    // Window enables by privilege level and lowest-index matching window.
    always_comb begin
        win_en_s   = '0;
        dmw_hit_s  = 1'b0;
        dmw_pseg_s = 3'b000;
        dmw_mat0_s = 1'b0;
        for (int i = 0; i < DMW_NUM; i++) begin
            win_en_s[i] = ((plv == 2'd3) && dmw_plv3[i]) || ((plv == 2'd0) && dmw_plv0[i]);
        end
        for (int i = DMW_NUM - 1; i >= 0; i--) begin
            if (win_en_s[i] && (req_addr[31:29] == dmw_vseg[3*i +: 3])) begin
                dmw_hit_s  = 1'b1;
                dmw_pseg_s = dmw_pseg[3*i +: 3];
                dmw_mat0_s = dmw_mat[2*i];
            end else begin
                dmw_hit_s  = dmw_hit_s;
                dmw_pseg_s = dmw_pseg_s;
                dmw_mat0_s = dmw_mat0_s;
            end
        end
    end

`ifdef DMMU_TLB_EN
    logic [TLB_ENTRIES-1:0] present_q;
    logic [19:0]            vppn_q [TLB_ENTRIES];
    logic [19:0]            ppn_q  [TLB_ENTRIES];
    logic [9:0]             asid_q [TLB_ENTRIES];
    logic [1:0]             plv_q  [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] g_q, v_q, d_q, mat0_q;
    logic                   tlb_hit_s;
    logic [IDX_W-1:0]       tlb_sel_s;

    // Present bits: invalidate-all clears every entry, a same-cycle write wins for its entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            present_q <= '0;
        end else begin
            if (tlb_inv_all) begin
                present_q <= '0;
            end
            if (tlb_we) begin
                present_q[tlb_idx] <= 1'b1;
            end
        end
    end

    // Entry payload storage; only meaningful while the entry is present.
    always_ff @(posedge clk) begin
        if (tlb_we) begin
            vppn_q[tlb_idx] <= tlb_vppn;
            ppn_q[tlb_idx]  <= tlb_ppn;
            asid_q[tlb_idx] <= tlb_asid;
            plv_q[tlb_idx]  <= tlb_plv;
            g_q[tlb_idx]    <= tlb_g;
            v_q[tlb_idx]    <= tlb_v;
            d_q[tlb_idx]    <= tlb_d;
            mat0_q[tlb_idx] <= tlb_mat[0];
        end
    end

    // Fully-associative match; scanning downwards leaves the lowest hitting index selected.
    always_comb begin
        tlb_hit_s = 1'b0;
        tlb_sel_s = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (present_q[i] && (vppn_q[i] == req_addr[31:12]) && (g_q[i] || (asid_q[i] == asid))) begin
                tlb_hit_s = 1'b1;
                tlb_sel_s = IDX_W'(i);
            end else begin
                tlb_hit_s = tlb_hit_s;
                tlb_sel_s = tlb_sel_s;
            end
        end
    end

    // TLB result and fault priority for a paged-mode window miss.
    always_comb begin
        miss_paddr_s = req_addr;
        miss_unc_s   = 1'b0;
        miss_exc_s   = EXC_NONE;
        if (!tlb_hit_s) begin
            miss_exc_s = EXC_TLBR;
        end else if (!v_q[tlb_sel_s]) begin
            miss_exc_s = req_store ? EXC_PIS : EXC_PIL;
        end else if (plv > plv_q[tlb_sel_s]) begin
            miss_exc_s = EXC_PPI;
        end else if (req_store && !d_q[tlb_sel_s]) begin
            miss_exc_s = EXC_PME;
        end else begin
            miss_paddr_s = {ppn_q[tlb_sel_s], req_addr[11:0]};
            miss_unc_s   = ~mat0_q[tlb_sel_s];
        end
    end

    assign unused_s = ^{dmw_mat, direct_d_mat, tlb_mat[1]};
`else
    // Legacy behaviour: a paged-mode window miss passes the address through untranslated.
    always_comb begin
        miss_paddr_s = req_addr;
        miss_unc_s   = ~direct_d_mat[0];
        miss_exc_s   = EXC_NONE;
    end

    assign unused_s = ^{dmw_mat, asid, tlb_we, tlb_idx, tlb_vppn, tlb_ppn, tlb_asid,
                        tlb_g, tlb_v, tlb_d, tlb_plv, tlb_mat, tlb_inv_all};
`endif

    // Response stage next state: capture on acceptance, drain on consume, otherwise hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        paddr_d      = paddr_q;
        uncache_d    = uncache_q;
        exc_d        = exc_q;
        if (accept_s) begin
            resp_valid_d = 1'b1;
            if (paged_s && dmw_hit_s) begin
                paddr_d   = {dmw_pseg_s, req_addr[28:0]};
                uncache_d = ~dmw_mat0_s;
                exc_d     = EXC_NONE;
            end else if (paged_s) begin
                paddr_d   = miss_paddr_s;
                uncache_d = miss_unc_s;
                exc_d     = miss_exc_s;
            end else begin
                paddr_d   = req_addr;
                uncache_d = ~direct_d_mat[0];
                exc_d     = EXC_NONE;
            end
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    // Response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            paddr_q      <= 32'h0000_0000;
            uncache_q    <= 1'b0;
            exc_q        <= EXC_NONE;
        end else begin
            resp_valid_q <= resp_valid_d;
            paddr_q      <= paddr_d;
            uncache_q    <= uncache_d;
            exc_q        <= exc_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign paddr      = paddr_q;
    assign uncache    = uncache_q;
    assign exc        = exc_q;

endmodule

// File: tb/tb_data_mmu.sv
// Scoreboard bench for data_mmu: stimulus pushes expected responses, a monitor
// pops and compares whenever a response is consumed.
module tb_data_mmu;

    localparam int DMW_NUM     = 2;
    localparam int TLB_ENTRIES = 8;
    localparam int IDX_W       = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid, req_ready, req_store;
    logic [31:0]          req_addr;
    logic [1:0]           plv, translate_mode, direct_d_mat;
    logic [9:0]           asid;
    logic [DMW_NUM-1:0]   dmw_plv0, dmw_plv3;
    logic [2*DMW_NUM-1:0] dmw_mat;
    logic [3*DMW_NUM-1:0] dmw_vseg, dmw_pseg;
    logic                 tlb_we, tlb_g, tlb_v, tlb_d, tlb_inv_all;
    logic [IDX_W-1:0]     tlb_idx;
    logic [19:0]          tlb_vppn, tlb_ppn;
    logic [9:0]           tlb_asid;
    logic [1:0]           tlb_plv, tlb_mat;
    logic                 resp_valid, resp_ready, uncache;
    logic [31:0]          paddr;
    logic [2:0]           exc;

    typedef struct {
        string       name;
        logic [31:0] paddr;
        logic        unc;
        logic [2:0]  exc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    data_mmu #(.DMW_NUM(DMW_NUM), .TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_store(req_store),
        .plv(plv), .asid(asid), .translate_mode(translate_mode), .direct_d_mat(direct_d_mat),
        .dmw_plv0(dmw_plv0), .dmw_plv3(dmw_plv3), .dmw_mat(dmw_mat),
        .dmw_vseg(dmw_vseg), .dmw_pseg(dmw_pseg),
        .tlb_we(tlb_we), .tlb_idx(tlb_idx), .tlb_vppn(tlb_vppn), .tlb_ppn(tlb_ppn),
        .tlb_asid(tlb_asid), .tlb_g(tlb_g), .tlb_v(tlb_v), .tlb_d(tlb_d),
        .tlb_plv(tlb_plv), .tlb_mat(tlb_mat), .tlb_inv_all(tlb_inv_all),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .paddr(paddr), .uncache(uncache), .exc(exc)
    );

    always #5 clk = ~clk;

    // Monitor: compare each consumed response against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_resp: got paddr=%h unc=%b exc=%0d with empty scoreboard",
                         paddr, uncache, exc);
            end else begin
                mon_e = sb.pop_front();
                if (paddr !== mon_e.paddr || uncache !== mon_e.unc || exc !== mon_e.exc) begin
                    n_err++;
                    $display("FAIL %s: got paddr=%h unc=%b exc=%0d, want paddr=%h unc=%b exc=%0d",
                             mon_e.name, paddr, uncache, exc, mon_e.paddr, mon_e.unc, mon_e.exc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endtask

    // Issue one request; the expectation is pushed at the acceptance edge.
    task automatic send(input string nm, input logic [31:0] a, input logic st,
                        input logic [31:0] ep, input logic eu, input logic [2:0] ee);
        exp_t e;
        int   k;
        req_addr  = a;
        req_store = st;
        req_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: req_ready stuck at %b, want 1", nm, req_ready);
            @(posedge clk);
            #1;
        end else begin
            e.name  = nm;
            e.paddr = ep;
            e.unc   = eu;
            e.exc   = ee;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    // Paged-mode window miss: TLB result when built, pass-through otherwise.
    task automatic send_tlb(input string nm, input logic [31:0] a, input logic st,
                            input logic [31:0] ep, input logic eu, input logic [2:0] ee);
`ifdef DMMU_TLB_EN
        send(nm, a, st, ep, eu, ee);
`else
        send(nm, a, st, a, ~direct_d_mat[0], 3'd0);
`endif
    endtask

    task automatic tlb_set(input logic [2:0] idx, input logic [19:0] vppn, input logic [19:0] ppn,
                           input logic [9:0] as, input logic g, input logic v, input logic d,
                           input logic [1:0] pl, input logic [1:0] mat);
        tlb_idx = idx; tlb_vppn = vppn; tlb_ppn = ppn; tlb_asid = as;
        tlb_g = g; tlb_v = v; tlb_d = d; tlb_plv = pl; tlb_mat = mat;
    endtask

    task automatic tlb_pulse_we();
        tlb_we = 1'b1;
        @(posedge clk);
        #1;
        tlb_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_store = 1'b0;
        plv = 2'd0; asid = 10'd0; translate_mode = 2'b01; direct_d_mat = 2'b01;
        dmw_plv0 = '0; dmw_plv3 = '0; dmw_mat = '0; dmw_vseg = '0; dmw_pseg = '0;
        tlb_we = 1'b0; tlb_inv_all = 1'b0; resp_ready = 1'b1;
        tlb_set(3'd0, 20'h0, 20'h0, 10'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_unc_exc", {28'd0, uncache, exc}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        // Direct mode (01, 00, 11)
        send("direct01", 32'h1C00_0040, 1'b0, 32'h1C00_0040, 1'b0, 3'd0);
        direct_d_mat = 2'b00; translate_mode = 2'b00;
        send("direct00", 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 3'd0);
        translate_mode = 2'b11;
        send("direct11", 32'hA000_1234, 1'b0, 32'hA000_1234, 1'b1, 3'd0);

        // DMW priority: both windows vseg 5, lower index wins
        translate_mode = 2'b10; plv = 2'd0;
        dmw_plv0 = 2'b11; dmw_vseg = {3'd5, 3'd5}; dmw_pseg = {3'd1, 3'd0}; dmw_mat = {2'd1, 2'd0};
        send("dmw_prio", 32'hA000_1234, 1'b0, 32'h0000_1234, 1'b1, 3'd0);
        dmw_plv0 = 2'b10;
        send("dmw_win1", 32'hA000_1234, 1'b1, 32'h2000_1234, 1'b0, 3'd0);
        plv = 2'd1;
        send_tlb("dmw_plv1_miss", 32'hA000_1234, 1'b0, 32'hA000_1234, 1'b0, 3'd1);
        plv = 2'd3; dmw_plv3 = 2'b01;
        send("dmw_plv3", 32'hA000_1234, 1'b0, 32'h0000_1234, 1'b1, 3'd0);

        // TLB hit / miss / faults (addresses outside window segment 5)
        asid = 10'd7;
        tlb_set(3'd3, 20'h00400, 20'h12345, 10'd0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd1);
        tlb_pulse_we();
        send_tlb("tlb_hit_ld", 32'h0040_0ABC, 1'b0, 32'h1234_5ABC, 1'b0, 3'd0);
        send_tlb("tlb_miss", 32'h0050_0000, 1'b0, 32'h0050_0000, 1'b0, 3'd1);
        send_tlb("tlb_hit_st", 32'h0040_0ABC, 1'b1, 32'h1234_5ABC, 1'b0, 3'd0);
        tlb_set(3'd5, 20'h00600, 20'hABCDE, 10'd7, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0);
        tlb_pulse_we();
        send_tlb("tlb_pme", 32'h0060_0010, 1'b1, 32'h0060_0010, 1'b0, 3'd5);
        send_tlb("tlb_asid_ld", 32'h0060_0010, 1'b0, 32'hABCD_E010, 1'b1, 3'd0);
        asid = 10'd8;
        send_tlb("tlb_asid_miss", 32'h0060_0010, 1'b0, 32'h0060_0010, 1'b0, 3'd1);
        tlb_set(3'd1, 20'h00700, 20'h11111, 10'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1);
        tlb_pulse_we();
        send_tlb("tlb_ppi", 32'h0070_0004, 1'b0, 32'h0070_0004, 1'b0, 3'd4);
        plv = 2'd0;
        send_tlb("tlb_plv0_ok", 32'h0070_0004, 1'b0, 32'h1111_1004, 1'b0, 3'd0);
        plv = 2'd3;
        tlb_set(3'd2, 20'h00800, 20'h22222, 10'd0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd1);
        tlb_pulse_we();
        send_tlb("tlb_pil", 32'h0080_0008, 1'b0, 32'h0080_0008, 1'b0, 3'd2);
        send_tlb("tlb_pis", 32'h0080_0008, 1'b1, 32'h0080_0008, 1'b0, 3'd3);
        tlb_set(3'd0, 20'h00400, 20'h33333, 10'd0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd1);
        tlb_pulse_we();
        send_tlb("tlb_lowidx", 32'h0040_0ABC, 1'b0, 32'h3333_3ABC, 1'b0, 3'd0);
        tlb_inv_all = 1'b1;
        @(posedge clk);
        #1;
        tlb_inv_all = 1'b0;
        send_tlb("tlb_inv", 32'h0040_0ABC, 1'b0, 32'h0040_0ABC, 1'b0, 3'd1);

        // Write/lookup race: same-cycle write is not yet visible
        tlb_set(3'd4, 20'h00900, 20'h44444, 10'd0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd1);
        tlb_we = 1'b1;
        send_tlb("race_old", 32'h0090_0123, 1'b0, 32'h0090_0123, 1'b0, 3'd1);
        tlb_we = 1'b0;
        send_tlb("race_new", 32'h0090_0123, 1'b0, 32'h4444_4123, 1'b0, 3'd0);

        // Write together with invalidate-all: written entry survives, others cleared
        tlb_set(3'd6, 20'h00A00, 20'h55555, 10'd0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd1);
        tlb_we = 1'b1; tlb_inv_all = 1'b1;
        @(posedge clk);
        #1;
        tlb_we = 1'b0; tlb_inv_all = 1'b0;
        send_tlb("we_inv_kept", 32'h00A0_0001, 1'b0, 32'h5555_5001, 1'b0, 3'd0);
        send_tlb("we_inv_gone", 32'h0090_0123, 1'b0, 32'h0090_0123, 1'b0, 3'd1);

        // Backpressure: stall with a waiting request, then drain back-to-back
        translate_mode = 2'b01; direct_d_mat = 2'b01;
        send("bp_a", 32'h1111_0000, 1'b0, 32'h1111_0000, 1'b0, 3'd0);
        resp_ready = 1'b0;
        req_addr = 32'h2222_0004; req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
            chk("bp_valid_held", {31'd0, resp_valid}, 32'd1);
            chk("bp_paddr_held", paddr, 32'h1111_0000);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        send("bp_b", 32'h2222_0004, 1'b0, 32'h2222_0004, 1'b0, 3'd0);
        send("bp_c", 32'h3333_0008, 1'b0, 32'h3333_0008, 1'b0, 3'd0);
        @(posedge clk);
        #1;

        // Mid-operation reset drops the pending response and clears the TLB
        resp_ready = 1'b0;
        send("rst_drop", 32'h4444_0000, 1'b0, 32'h4444_0000, 1'b0, 3'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("rst2_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst2_paddr", paddr, 32'h0);
        resp_ready = 1'b1;
        translate_mode = 2'b10; plv = 2'd3; direct_d_mat = 2'b00;
        send_tlb("rst2_tlb_clear", 32'h00A0_0001, 1'b0, 32'h00A0_0001, 1'b0, 3'd1);

        // Drain remaining expectations with a bound
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
